// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 constants (FK, CK, S-box) and the mode-engine enums.
package sm4_encryptor_pkg;

  localparam int group_size_p = 4;
  localparam int word_width_p = 32;

  localparam logic [127:0] key_xor_mask_p = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [0:31][31:0] key_aux_p = {
    128'h00070e15_1c232a31_383f464d_545b6269,
    128'h70777e85_8c939aa1_a8afb6bd_c4cbd2d9,
    128'he0e7eef5_fc030a11_181f262d_343b4249,
    128'h50575e65_6c737a81_888f969d_a4abb2b9,
    128'hc0c7ced5_dce3eaf1_f8ff060d_141b2229,
    128'h30373e45_4c535a61_686f767d_848b9299,
    128'ha0a7aeb5_bcc3cad1_d8dfe6ed_f4fb0209,
    128'h10171e25_2c333a41_484f565d_646b7279
  };

  localparam logic [0:255][7:0] sbox_p = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {eEcb = 2'd0, eCbc = 2'd1, eCtr = 2'd2, eRsvd = 2'd3} sm4_mode_e;

  typedef enum logic [2:0] {eIdle, eKeyExp, eCrypt, eFinish, eDone} sm4_mode_state_e;

  function automatic logic [127:0] word_rev(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

endpackage

// File: rtl/turn_transform.sv
// One SM4 round: key-schedule transform (L') or cipher transform (L) on a 4-word state.
module turn_transform
  import sm4_encryptor_pkg::*;
(
  input  logic [127:0]            state_i,
  input  logic [word_width_p-1:0] rk_i,
  input  logic                    is_key_i,
  output logic [127:0]            state_o,
  output logic [word_width_p-1:0] word_o
);

  logic [word_width_p-1:0] mix;
  logic [word_width_p-1:0] sub;
  logic [word_width_p-1:0] lin;

  always_comb begin
    mix = state_i[95:64] ^ state_i[63:32] ^ state_i[31:0] ^ rk_i;
    sub = '0;
    for (int b = 0; b < 4; b++) sub[8*b +: 8] = sbox_p[mix[8*b +: 8]];
    if (is_key_i) begin
      lin = sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};
    end else begin
      lin = sub ^ {sub[29:0], sub[31:30]} ^ {sub[21:0], sub[31:22]}
                ^ {sub[13:0], sub[31:14]} ^ {sub[7:0], sub[31:8]};
    end
    word_o  = state_i[127:96] ^ lin;
    state_o = {state_i[95:0], word_o};
  end

endmodule

// File: rtl/sm4_mode_engine.sv
// SM4 engine with ECB/CBC/CTR chaining; key expansion and cipher rounds share one
// chain of rounds_per_cycle_p round transforms.
module sm4_mode_engine
  import sm4_encryptor_pkg::*;
#(
  parameter int rounds_per_cycle_p = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [127:0] key_i,
  input  logic [127:0] iv_i,
  input  logic [1:0]   mode_i,
  input  logic         decode_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  input  logic [127:0] content_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [127:0] crypt_o,
  output logic         v_o,
  input  logic         yumi_i
);

  localparam int         block_w_lp  = group_size_p * word_width_p;
  localparam logic [4:0] step_lp     = 5'(rounds_per_cycle_p);
  localparam logic [4:0] last_cnt_lp = 5'(32 - rounds_per_cycle_p);

  sm4_mode_state_e state_q, state_d;
  sm4_mode_e       mode_q;
  logic            decode_q;
  logic            key_valid_q;
  logic [4:0]      cnt_q;
  logic [block_w_lp-1:0] sfr_q, chain_q, in_q, crypt_q;
  logic [word_width_p-1:0] rk_q [32];

  logic key_phase, dec_eff, last_round, data_ok;
  logic [block_w_lp-1:0] blk_in, rev, result, chain_nxt;
  logic [block_w_lp-1:0]   st       [rounds_per_cycle_p+1];
  logic [word_width_p-1:0] new_word [rounds_per_cycle_p];

  assign key_phase  = (state_q == eKeyExp);
  assign dec_eff    = decode_q && (mode_q != eCtr);
  assign last_round = (cnt_q == last_cnt_lp);
  assign st[0]      = sfr_q;
  assign crypt_o    = crypt_q;

  // Round k of this cycle is absolute round cnt_q + k; decrypt walks the key file backwards.
  for (genvar k = 0; k < rounds_per_cycle_p; k++) begin : g_round
    logic [4:0]              idx;
    logic [4:0]              rd_idx;
    logic [word_width_p-1:0] rk_sel;
    assign idx    = cnt_q + 5'(k);
    assign rd_idx = dec_eff ? (5'd31 - idx) : idx;
    assign rk_sel = key_phase ? key_aux_p[idx] : rk_q[rd_idx];
    turn_transform u_turn (
      .state_i  (st[k]),
      .rk_i     (rk_sel),
      .is_key_i (key_phase),
      .state_o  (st[k+1]),
      .word_o   (new_word[k])
    );
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= eIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    key_ready_o = 1'b0;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    data_ok     = key_valid_q && !key_v_i;
    case (state_q)
      eIdle: begin
        key_ready_o = 1'b1;
        ready_o     = data_ok;
        if (key_v_i)            state_d = eKeyExp;
        else if (v_i && data_ok) state_d = eCrypt;
      end
      eKeyExp: if (last_round) state_d = eIdle;
      eCrypt:  if (last_round) state_d = eFinish;
      eFinish: state_d = eDone;
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase
  end

  always_comb begin
    blk_in = content_i;
    case (mode_q)
      eCbc:    if (!decode_q) blk_in = content_i ^ chain_q;
      eCtr:    blk_in = chain_q;
      default: blk_in = content_i;
    endcase
  end

  always_comb begin
    rev       = word_rev(sfr_q);
    result    = rev;
    chain_nxt = rev;
    case (mode_q)
      eCbc: if (decode_q) begin
        result    = rev ^ chain_q;
        chain_nxt = in_q;
      end
      eCtr: begin
        result    = rev ^ in_q;
        chain_nxt = chain_q + 128'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mode_q      <= eEcb;
      decode_q    <= 1'b0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      sfr_q       <= '0;
      chain_q     <= '0;
      in_q        <= '0;
      crypt_q     <= '0;
    end else begin
      case (state_q)
        eIdle: begin
          if (key_v_i) begin
            mode_q      <= sm4_mode_e'(mode_i);
            decode_q    <= decode_i;
            chain_q     <= iv_i;
            key_valid_q <= 1'b0;
            sfr_q       <= key_i ^ key_xor_mask_p;
          end else if (v_i && key_valid_q) begin
            sfr_q <= blk_in;
            in_q  <= content_i;
          end
        end
        // The counter wraps back to zero on the final step, ready for the next phase.
        eKeyExp, eCrypt: begin
          sfr_q <= st[rounds_per_cycle_p];
          cnt_q <= cnt_q + step_lp;
          if (key_phase && last_round) key_valid_q <= 1'b1;
        end
        eFinish: begin
          crypt_q <= result;
          chain_q <= chain_nxt;
        end
        default: ;
      endcase
    end
  end

  // Round-key file holds its contents across reset; a reload always rewrites all 32 entries.
  always_ff @(posedge clk_i) begin
    if (key_phase) begin
      for (int k = 0; k < rounds_per_cycle_p; k++) rk_q[cnt_q + 5'(k)] <= new_word[k];
    end
  end

endmodule

// File: tb/tb_sm4_mode_engine.sv
// Bench for sm4_mode_engine: R=1 and R=4 instances driven in lockstep, checked against
// directed vectors and a behavioural SM4 reference.
module tb_sm4_mode_engine;

  localparam logic [127:0] P    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0   = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] XIV  = 128'hdeadbeef00112233445566778899aabb;
  localparam logic [127:0] XD   = 128'h55aa55aa0f0f0f0f1234567890abcdef;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, decode, key_v, v_in, yumi;
  logic [1:0]   mode;
  logic [127:0] key, iv, content;
  logic         key_ready1, ready1, v1, key_ready4, ready4, v4;
  logic [127:0] crypt1, crypt4;

  int n_pass = 0;
  int n_checks = 0;

  sm4_mode_engine #(.rounds_per_cycle_p(1)) u_dut1 (
    .clk_i(clk), .reset_ni(reset_n), .key_i(key), .iv_i(iv), .mode_i(mode),
    .decode_i(decode), .key_v_i(key_v), .key_ready_o(key_ready1), .content_i(content),
    .v_i(v_in), .ready_o(ready1), .crypt_o(crypt1), .v_o(v1), .yumi_i(yumi)
  );

  sm4_mode_engine #(.rounds_per_cycle_p(4)) u_dut4 (
    .clk_i(clk), .reset_ni(reset_n), .key_i(key), .iv_i(iv), .mode_i(mode),
    .decode_i(decode), .key_v_i(key_v), .key_ready_o(key_ready4), .content_i(content),
    .v_i(v_in), .ready_o(ready4), .crypt_o(crypt4), .v_o(v4), .yumi_i(yumi)
  );

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ref_t(input logic [31:0] x, input bit is_key);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = SB[x[8*i +: 8]];
    if (is_key) return b ^ rol32(b, 13) ^ rol32(b, 23);
    return b ^ rol32(b, 2) ^ rol32(b, 10) ^ rol32(b, 18) ^ rol32(b, 24);
  endfunction

  function automatic logic [127:0] ref_sm4(input logic [127:0] k_in, input logic [127:0] blk,
                                           input bit dec);
    logic [31:0]  k  [36];
    logic [31:0]  x  [36];
    logic [31:0]  rk [32];
    logic [31:0]  ck;
    logic [127:0] fk;
    fk = 128'ha3b1bac656aa3350677d9197b27022dc;
    for (int i = 0; i < 4; i++) begin
      k[i] = k_in[127-32*i -: 32] ^ fk[127-32*i -: 32];
      x[i] = blk[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ ref_t(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck, 1'b1);
      rk[i]  = k[i+4];
    end
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ ref_t(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]), 1'b0);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_key(input logic [1:0] m, input bit d, input logic [127:0] ivv,
                          input logic [127:0] kk, input string name);
    int lat1, lat4;
    @(negedge clk);
    chk({name, "_key_ready"}, 128'({key_ready1, key_ready4}), 128'b11);
    key = kk; iv = ivv; mode = m; decode = d; key_v = 1'b1;
    @(posedge clk); #1;
    key_v = 1'b0; key = ~kk; iv = ~ivv; mode = ~m; decode = ~d;
    lat1 = -1; lat4 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (lat1 < 0 && ready1) lat1 = n;
      if (lat4 < 0 && ready4) lat4 = n;
      if (lat1 >= 0 && lat4 >= 0) break;
    end
    chk({name, "_keylat_r1"}, 128'(lat1), 128'd33);
    chk({name, "_keylat_r4"}, 128'(lat4), 128'd9);
  endtask

  task automatic send_block(input logic [127:0] din, input logic [127:0] exp,
                            input string name, input int hold);
    int lat1, lat4;
    logic [127:0] s1, s4;
    bit stable;
    @(negedge clk);
    chk({name, "_ready"}, 128'({ready1, ready4}), 128'b11);
    content = din; v_in = 1'b1;
    @(posedge clk); #1;
    v_in = 1'b0; content = ~din;
    lat1 = -1; lat4 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (lat1 < 0 && v1) lat1 = n;
      if (lat4 < 0 && v4) lat4 = n;
      if (lat1 >= 0 && lat4 >= 0) break;
    end
    chk({name, "_lat_r1"}, 128'(lat1), 128'd34);
    chk({name, "_lat_r4"}, 128'(lat4), 128'd10);
    chk({name, "_crypt_r1"}, crypt1, exp);
    chk({name, "_crypt_r4"}, crypt4, exp);
    if (hold > 0) begin
      s1 = crypt1; s4 = crypt4; stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!v1 || !v4 || crypt1 !== s1 || crypt4 !== s4) stable = 1'b0;
      end
      chk({name, "_hold_stable"}, 128'(stable), 128'd1);
    end
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
  endtask

  typedef struct {
    string        name;
    bit           load;
    logic [1:0]   mode;
    bit           dec;
    logic [127:0] iv;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] c1, e_ones, e_zero;
    bit ok, seen_v;

    c1     = ref_sm4(P, P ^ C0, 1'b0);
    e_ones = ref_sm4(P, ONES, 1'b0);
    e_zero = ref_sm4(P, '0, 1'b0);
    vecs.push_back('{"ecb_enc",    1'b1, 2'd0, 1'b0, '0,   P,  P,   C0});
    vecs.push_back('{"ecb_dec",    1'b1, 2'd0, 1'b1, '0,   P,  C0,  P});
    vecs.push_back('{"rsvd_enc",   1'b1, 2'd3, 1'b0, '0,   P,  P,   C0});
    vecs.push_back('{"cbc_enc1",   1'b1, 2'd1, 1'b0, '0,   P,  P,   C0});
    vecs.push_back('{"cbc_enc2",   1'b0, 2'd1, 1'b0, '0,   P,  P,   c1});
    vecs.push_back('{"cbc_rekey",  1'b1, 2'd1, 1'b0, '0,   P,  P,   C0});
    vecs.push_back('{"cbc_dec1",   1'b1, 2'd1, 1'b1, '0,   P,  C0,  P});
    vecs.push_back('{"cbc_dec2",   1'b0, 2'd1, 1'b1, '0,   P,  c1,  P});
    vecs.push_back('{"ctr_enc1",   1'b1, 2'd2, 1'b0, ONES, P,  P,   P ^ e_ones});
    vecs.push_back('{"ctr_enc2",   1'b0, 2'd2, 1'b0, ONES, P,  P,   P ^ e_zero});
    vecs.push_back('{"ctr_dec1",   1'b1, 2'd2, 1'b1, ONES, P,  P,   P ^ e_ones});
    vecs.push_back('{"ctr_dec2",   1'b0, 2'd2, 1'b1, ONES, P,  P,   P ^ e_zero});
    vecs.push_back('{"cbc_iv_k2",  1'b1, 2'd1, 1'b0, XIV,  K2, XD,  ref_sm4(K2, XD ^ XIV, 1'b0)});
    vecs.push_back('{"ecb_dec_k2", 1'b1, 2'd0, 1'b1, '0,   K2, XD,  ref_sm4(K2, XD, 1'b1)});

    reset_n = 1'b0; key_v = 1'b0; v_in = 1'b0; yumi = 1'b0;
    mode = 2'd0; decode = 1'b0; key = '0; iv = '0; content = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl_r1", 128'({key_ready1, ready1, v1}), 128'b100);
    chk("reset_ctrl_r4", 128'({key_ready4, ready4, v4}), 128'b100);
    chk("reset_crypt_r1", crypt1, '0);
    chk("reset_crypt_r4", crypt4, '0);
    reset_n = 1'b1;
    v_in = 1'b1; content = P; ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready1 || ready4 || v1 || v4) ok = 1'b0;
    end
    v_in = 1'b0;
    chk("no_session_ready_low", 128'(ok), 128'd1);

    foreach (vecs[i]) begin
      if (vecs[i].load) load_key(vecs[i].mode, vecs[i].dec, vecs[i].iv, vecs[i].key, vecs[i].name);
      send_block(vecs[i].din, vecs[i].exp, vecs[i].name, 0);
    end

    // Key and data presented together: key load wins, the block is dropped.
    @(negedge clk);
    key = P; iv = '0; mode = 2'd0; decode = 1'b0; key_v = 1'b1; v_in = 1'b1; content = P;
    #1;
    chk("keywins_ready_low", 128'({ready1, ready4}), 128'b00);
    @(posedge clk); #1;
    key_v = 1'b0; v_in = 1'b0;
    seen_v = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (v1 || v4) seen_v = 1'b1;
      if (ready1 && ready4) break;
    end
    chk("keywins_session_ready", 128'({ready1, ready4}), 128'b11);
    chk("keywins_no_output", 128'(seen_v), 128'd0);

    send_block(P, C0, "hold_yumi_low", 6);

    // Asynchronous reset while both instances are mid-round.
    @(negedge clk);
    content = P; v_in = 1'b1;
    @(posedge clk); #1;
    v_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl_r1", 128'({key_ready1, ready1, v1}), 128'b100);
    chk("async_rst_ctrl_r4", 128'({key_ready4, ready4, v4}), 128'b100);
    chk("async_rst_crypt_r1", crypt1, '0);
    chk("async_rst_crypt_r4", crypt4, '0);
    @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ready1 || ready4 || v1 || v4) ok = 1'b0;
    end
    chk("after_rst_needs_key", 128'(ok), 128'd1);

    load_key(2'd0, 1'b1, '0, P, "reload");
    send_block(C0, P, "reload_ecb_dec", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
